// File: rtl/sbus_ext_bridge_if.sv
// ---------------------------------------------------------------------------
// sbus - physical sbus between the core's uncached data path and a responder.
//
// Signals
//   en      master -> slave  transaction request, held until stall drops
//   we      master -> slave  1 = write, 0 = read
//   size    master -> slave  0 = byte, 1 = halfword, 2 = word, 3 = reserved
//   addr    master -> slave  byte address
//   data_w  master -> slave  write data, right-aligned
//   data_r  slave -> master  read data / completion status
//   stall   slave -> master  hold the master while the transaction is pending
// ---------------------------------------------------------------------------
interface sbus;
  logic        en;
  logic        we;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] data_w;
  logic [31:0] data_r;
  logic        stall;

  modport master (
    output en, we, size, addr, data_w,
    input  data_r, stall
  );

  modport slave (
    input  en, we, size, addr, data_w,
    output data_r, stall
  );
endinterface

// File: rtl/sbus_ext_bridge.sv
// ---------------------------------------------------------------------------
// sbus_ext_bridge - responder end of the sbus, bridging one transaction at a
// time onto a registered req/ack external bus of variable latency.
//
// The core is held with stall while the request is outstanding. The bridge
// produces word-aligned addresses, byte enables from size/addr[1:0],
// lane-replicated write data, and abandons a request that is not acknowledged
// within TIMEOUT+1 request cycles (TIMEOUT = 0 waits forever).
//
// Ports
//   clk        clock
//   rst_n      asynchronous active-low reset
//   bus        sbus slave modport (en/we/size/addr/data_w in, data_r/stall out)
//   ext_req    external request valid (registered)
//   ext_we     external write
//   ext_addr   word address {addr[31:2], 2'b00}
//   ext_be     byte enables
//   ext_wdata  lane-replicated write data
//   ext_ack    external completion, only looked at while a request is out
//   ext_rdata  external read data, valid with ext_ack
//   bus_err    one-cycle pulse when a request times out
// ---------------------------------------------------------------------------
module sbus_ext_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  sbus.slave          bus,
  output logic        ext_req,
  output logic        ext_we,
  output logic [31:0] ext_addr,
  output logic [3:0]  ext_be,
  output logic [31:0] ext_wdata,
  input  logic        ext_ack,
  input  logic [31:0] ext_rdata,
  output logic        bus_err
);

  // Counter only needs to reach TIMEOUT; keep at least one bit so the
  // declaration stays legal when the timeout is disabled.
  localparam int unsigned      CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT);
  localparam bit               TMO_EN   = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;
  logic [31:0]      data_r_q;

  // Byte enables for the addressed lanes. A misaligned halfword keeps the
  // addr[1] half; addr[0] is deliberately ignored. The reserved size 3 is
  // treated as a full word.
  function automatic logic [3:0] byte_enables(input logic [1:0] size,
                                              input logic [1:0] low);
    logic [3:0] be;
    case (size)
      2'd0:    be = 4'b0001 << low;
      2'd1:    be = low[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate narrow write data across every lane so the external side can
  // pick the bytes it needs with ext_be alone.
  function automatic logic [31:0] lane_data(input logic [1:0]  size,
                                            input logic [31:0] d);
    logic [31:0] w;
    case (size)
      2'd0:    w = {4{d[7:0]}};
      2'd1:    w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // stall is combinational so the master sees it in the same cycle it raises
  // en. It only drops in DONE, which is also the cycle data_r is valid. A
  // flushed master (en = 0) is never stalled, even while the external
  // transfer is still running.
  assign bus.stall  = bus.en & (state != DONE);
  assign bus.data_r = data_r_q;

  // Transaction sequencer. IDLE captures the request into the ext_*
  // registers, REQ holds them stable until ack or timeout, DONE presents the
  // response for one cycle. The ext_* registers keep their values after the
  // transfer, so nothing is re-issued until the next IDLE capture. An ack
  // arriving in the timeout cycle still wins. bus_err defaults low so the
  // timeout pulse lasts exactly the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      ext_req   <= 1'b0;
      ext_we    <= 1'b0;
      ext_addr  <= '0;
      ext_be    <= '0;
      ext_wdata <= '0;
      data_r_q  <= '0;
      bus_err   <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.en) begin
            ext_req   <= 1'b1;
            ext_we    <= bus.we;
            ext_addr  <= {bus.addr[31:2], 2'b00};
            ext_be    <= byte_enables(bus.size, bus.addr[1:0]);
            ext_wdata <= lane_data(bus.size, bus.data_w);
            tmo_cnt   <= '0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (ext_ack) begin
            data_r_q <= ext_we ? 32'h0000_0000 : ext_rdata;
            ext_req  <= 1'b0;
            state    <= DONE;
          end else if (TMO_EN && (tmo_cnt == CNT_LAST)) begin
            data_r_q <= 32'hFFFF_FFFF;
            bus_err  <= 1'b1;
            ext_req  <= 1'b0;
            state    <= DONE;
          end else if (TMO_EN) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          ext_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sbus_ext_bridge.sv
// ---------------------------------------------------------------------------
// tb_sbus_ext_bridge - self-checking bench for sbus_ext_bridge.
//
// Main instance (TIMEOUT = 8) is driven a transaction at a time. The driver
// works out the expected outputs of every cycle from the transaction itself
// (3 + N cycle latency, timeout after TIMEOUT+1 request cycles, arithmetic
// byte-enable / lane rules). A negedge process compares the DUT against them.
// A second instance (TIMEOUT = 4) never gets an ack and exercises the timeout.
// ---------------------------------------------------------------------------
module tb_sbus_ext_bridge;

  localparam int MAIN_TMO = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  sbus bus_m ();
  sbus bus_t ();

  logic        ext_req, ext_we, ext_ack, bus_err;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;
  logic [3:0]  ext_be;

  logic        t_req, t_we, t_ack, t_err;
  logic [31:0] t_addr, t_wdata, t_rdata;
  logic [3:0]  t_be;

  sbus_ext_bridge #(.TIMEOUT(MAIN_TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_m),
    .ext_req   (ext_req),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_be    (ext_be),
    .ext_wdata (ext_wdata),
    .ext_ack   (ext_ack),
    .ext_rdata (ext_rdata),
    .bus_err   (bus_err)
  );

  sbus_ext_bridge #(.TIMEOUT(4)) dut_t (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_t),
    .ext_req   (t_req),
    .ext_we    (t_we),
    .ext_addr  (t_addr),
    .ext_be    (t_be),
    .ext_wdata (t_wdata),
    .ext_ack   (t_ack),
    .ext_rdata (t_rdata),
    .bus_err   (t_err)
  );

  int checks = 0;
  int errors = 0;

  // Expected state of the main instance, maintained by the driver
  bit          chk_on = 1'b0;
  bit          chk_dr = 1'b0;
  bit          force_stray = 1'b0;
  logic        e_req, e_we, e_stall, e_err;
  logic [31:0] e_addr, e_wdata, e_data_r;
  logic [3:0]  e_be;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd0) return 4'(1 << addr[1:0]);
    if (size == 2'd1) return 4'(3 << (addr[1] ? 2 : 0));
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] d);
    if (size == 2'd0) return 32'(d[7:0]) * 32'h0101_0101;
    if (size == 2'd1) return 32'(d[15:0]) * 32'h0001_0001;
    return d;
  endfunction

  task automatic model_reset();
    e_req = 0; e_we = 0; e_addr = 0; e_be = 0; e_wdata = 0;
    e_data_r = 0; e_err = 0; e_stall = 0; chk_dr = 1'b1;
  endtask

  // Compare the main instance against the expectations every cycle
  always @(negedge clk) begin
    if (chk_on && rst_n) begin
      check_output("ext_req",   32'(ext_req),      32'(e_req));
      check_output("ext_we",    32'(ext_we),       32'(e_we));
      check_output("ext_addr",  ext_addr,          e_addr);
      check_output("ext_be",    32'(ext_be),       32'(e_be));
      check_output("ext_wdata", ext_wdata,         e_wdata);
      check_output("stall",     32'(bus_m.stall),  32'(e_stall));
      check_output("bus_err",   32'(bus_err),      32'(e_err));
      if (chk_dr) check_output("data_r", bus_m.data_r, e_data_r);
    end
  end

  // Idle cycles with garbage on the bus and stray acks
  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus_m.en = 1'b0; bus_m.we = 1'($urandom); bus_m.size = 2'($urandom);
      bus_m.addr = $urandom; bus_m.data_w = $urandom;
      ext_ack = 1'($urandom); ext_rdata = $urandom;
      e_req = 0; e_stall = 0; e_err = 0;
    end
  endtask

  // One transaction: ack after 'delay' unacked REQ cycles (timeout if
  // delay > MAIN_TMO); en dropped from REQ cycle 'flush_at' on (-1: never).
  // Returns inside the DONE cycle.
  task automatic apply_stimulus(input bit we, input logic [1:0] size,
                                input logic [31:0] addr, input logic [31:0] data_w,
                                input logic [31:0] rdata, input int delay,
                                input int flush_at);
    bit timed_out, flushed;
    int n_req;
    timed_out = (delay > MAIN_TMO);
    n_req     = timed_out ? MAIN_TMO + 1 : delay + 1;
    flushed   = (flush_at >= 1) && (flush_at <= n_req);

    @(posedge clk); #1;
    bus_m.en = 1'b1; bus_m.we = we; bus_m.size = size;
    bus_m.addr = addr; bus_m.data_w = data_w;
    ext_ack = force_stray | 1'($urandom); ext_rdata = $urandom;
    e_req = 0; e_stall = 1; e_err = 0;

    for (int i = 1; i <= n_req; i++) begin
      @(posedge clk); #1;
      if (flushed && i >= flush_at) begin
        bus_m.en = 1'b0; bus_m.we = 1'($urandom); bus_m.size = 2'($urandom);
        bus_m.addr = $urandom; bus_m.data_w = $urandom;
      end
      ext_ack   = !timed_out && (i == n_req);
      ext_rdata = ext_ack ? rdata : $urandom;
      e_req = 1; e_we = we; e_addr = {addr[31:2], 2'b00};
      e_be = model_be(size, addr); e_wdata = model_wdata(size, data_w);
      e_stall = bus_m.en; e_err = 0;
    end

    @(posedge clk); #1;
    ext_ack = force_stray | 1'($urandom); ext_rdata = $urandom;
    e_req = 0; e_stall = 0; e_err = timed_out;
    if (flushed) chk_dr = 1'b0;
    else begin
      chk_dr = 1'b1;
      e_data_r = timed_out ? 32'hFFFF_FFFF : (we ? 32'h0 : rdata);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before limit");
    $fatal;
  end

  initial begin
    int cyc;
    rst_n = 1'b0;
    bus_m.en = 0; bus_m.we = 0; bus_m.size = 0; bus_m.addr = 0; bus_m.data_w = 0;
    bus_t.en = 0; bus_t.we = 0; bus_t.size = 0; bus_t.addr = 0; bus_t.data_w = 0;
    ext_ack = 0; ext_rdata = 0; t_ack = 0; t_rdata = 32'hDEAD_BEEF;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_output("rst ext_req",   32'(ext_req),   0);
    check_output("rst ext_addr",  ext_addr,       0);
    check_output("rst ext_be",    32'(ext_be),    0);
    check_output("rst ext_wdata", ext_wdata,      0);
    check_output("rst data_r",    bus_m.data_r,   0);
    check_output("rst bus_err",   32'(bus_err),   0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    chk_on = 1'b1;

    // Timeout on the TIMEOUT=4 instance, no ack ever
    @(posedge clk); #1;
    bus_t.en = 1; bus_t.we = 0; bus_t.size = 2; bus_t.addr = 32'h0000_0040;
    cyc = 0;
    @(negedge clk);
    while (bus_t.stall && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check_output("tmo ext_req in REQ", 32'(t_req), 1);
    end
    check_output("tmo DONE cycle", 32'(cyc), 6);
    check_output("tmo bus_err", 32'(t_err), 1);
    check_output("tmo data_r", bus_t.data_r, 32'hFFFF_FFFF);
    check_output("tmo ext_req", 32'(t_req), 0);
    @(posedge clk); #1;
    bus_t.en = 0;
    @(negedge clk);
    check_output("tmo bus_err pulse", 32'(t_err), 0);
    check_output("tmo data_r hold", bus_t.data_r, 32'hFFFF_FFFF);

    // Read word, ack in first REQ cycle
    apply_stimulus(1'b0, 2'd2, 32'h1FC0_0006, 32'h0, 32'hCAFE_F00D, 0, -1);
    @(negedge clk);
    check_output("rd ext_addr", ext_addr, 32'h1FC0_0004);
    check_output("rd ext_be", 32'(ext_be), 32'hF);
    check_output("rd data_r", bus_m.data_r, 32'hCAFE_F00D);

    // Byte write
    apply_stimulus(1'b1, 2'd0, 32'h0000_0103, 32'h0000_00A5, $urandom, 0, -1);
    @(negedge clk);
    check_output("bw ext_be", 32'(ext_be), 32'h8);
    check_output("bw ext_wdata", ext_wdata, 32'hA5A5_A5A5);
    check_output("bw ext_we", 32'(ext_we), 1);
    check_output("bw data_r", bus_m.data_r, 0);

    // Halfword write, ack delayed 5 cycles
    idle_cycles(1);
    apply_stimulus(1'b1, 2'd1, 32'h0000_2002, 32'h0000_1234, $urandom, 5, -1);
    @(negedge clk);
    check_output("hw ext_be", 32'(ext_be), 32'hC);
    check_output("hw ext_wdata", ext_wdata, 32'h1234_1234);

    // Flush: en dropped in second REQ cycle of a write, then a normal read
    apply_stimulus(1'b1, 2'd2, 32'h0000_0200, 32'h7777_0000, $urandom, 4, 2);
    idle_cycles(1);
    apply_stimulus(1'b0, 2'd2, 32'h0000_0080, 32'h0, 32'h1357_9BDF, 1, -1);
    @(negedge clk);
    check_output("flush next read", bus_m.data_r, 32'h1357_9BDF);

    // Asynchronous reset mid-REQ
    @(posedge clk); #1;
    chk_on = 1'b0;
    bus_m.en = 1; bus_m.we = 1; bus_m.size = 2; bus_m.addr = 32'h3000_0010;
    bus_m.data_w = 32'h0000_55AA; ext_ack = 0;
    @(posedge clk); #1;
    check_output("arst pre ext_req", 32'(ext_req), 1);
    #2 rst_n = 1'b0;
    #1;
    check_output("arst ext_req", 32'(ext_req), 0);
    check_output("arst ext_we", 32'(ext_we), 0);
    check_output("arst ext_addr", ext_addr, 0);
    check_output("arst ext_be", 32'(ext_be), 0);
    check_output("arst ext_wdata", ext_wdata, 0);
    check_output("arst data_r", bus_m.data_r, 0);
    check_output("arst bus_err", 32'(bus_err), 0);
    bus_m.en = 0; ext_ack = 1;
    @(posedge clk); #3;
    rst_n = 1'b1;
    model_reset();
    chk_on = 1'b1;
    force_stray = 1'b1;
    apply_stimulus(1'b0, 2'd2, 32'h0000_0500, 32'h0, 32'h0BAD_CAFE, 0, -1);
    @(negedge clk);
    check_output("arst read 1", bus_m.data_r, 32'h0BAD_CAFE);
    apply_stimulus(1'b0, 2'd0, 32'h0000_0601, 32'h0, 32'h2468_ACE0, 0, -1);
    @(negedge clk);
    check_output("arst read 2", bus_m.data_r, 32'h2468_ACE0);
    force_stray = 1'b0;

    // Randomized traffic, including timeouts and flushes
    repeat (60) begin
      int fl;
      fl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 4)) : -1;
      apply_stimulus(1'($urandom), 2'($urandom), $urandom, $urandom, $urandom,
                     int'($urandom_range(0, 10)), fl);
      if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 2)));
    end
    idle_cycles(2);
    @(negedge clk);
    chk_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
